// File: rtl/rv64_multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV64 core: FETCH/DECODE/EXEC/MEM/WB with memory handshakes.
// Optional macro RV64_CTRL_PERF_EN adds cycle_cnt/instret_cnt performance counters.
module rv64_multicycle_ctrl #(
  parameter bit RESET_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [6:0]  ir_opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        illegal_insn,
  output logic [2:0]  state_o
`ifdef RV64_CTRL_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_LOAD, C_STORE, C_OPIMM, C_OP, C_AUIPC, C_LUI, C_BRANCH, C_JAL, C_JALR, C_NONE
  } iclass_t;

  state_t  state;
  iclass_t iclass;
  iclass_t dec_class;
  state_t  done_state;

  function automatic iclass_t decode_class(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_OPIMM;
      7'b0110011: return C_OP;
      7'b0010111: return C_AUIPC;
      7'b0110111: return C_LUI;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_NONE;
    endcase
  endfunction

  always_comb begin
    dec_class  = decode_class(ir_opcode);
    done_state = run ? S_FETCH : S_IDLE;
  end

  // Sequencing: the class is captured once in DECODE so later states ignore ir_opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      iclass <= C_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (run || RESET_RUN)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready)
            state <= S_DECODE;
        end
        S_DECODE: begin
          iclass <= dec_class;
          state  <= (dec_class == C_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          if (iclass == C_LOAD || iclass == C_STORE)
            state <= S_MEM;
          else if (iclass == C_BRANCH)
            state <= done_state;
          else
            state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready)
            state <= (iclass == C_STORE) ? done_state : S_WB;
        end
        S_WB:    state <= done_state;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the registered state, so async reset drops them at once.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_op    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        case (iclass)
          C_BRANCH: alu_op = 2'b01;
          C_OP:     alu_op = 2'b10;
          C_OPIMM:  alu_op = 2'b11;
          default:  alu_op = 2'b00;
        endcase
        alu_src_a = (iclass == C_AUIPC) || (iclass == C_JAL);
        alu_src_b = !((iclass == C_OP) || (iclass == C_BRANCH));
        if (iclass == C_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (iclass == C_STORE);
        pc_write = (iclass == C_STORE) && dmem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        case (iclass)
          C_LOAD:        wb_sel = 2'b01;
          C_JAL, C_JALR: wb_sel = 2'b10;
          C_LUI:         wb_sel = 2'b11;
          default:       wb_sel = 2'b00;
        endcase
        case (iclass)
          C_JAL:   pc_src = 2'b01;
          C_JALR:  pc_src = 2'b10;
          default: pc_src = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal_insn = (state == S_TRAP);
  assign state_o      = state;

`ifdef RV64_CTRL_PERF_EN
  // Free-running 64-bit counters; wrap naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (state != S_IDLE && state != S_TRAP)
        cycle_cnt <= cycle_cnt + 64'd1;
      if (pc_write)
        instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv64_multicycle_ctrl.sv
// Directed self-checking bench for rv64_multicycle_ctrl; perf counters checked when RV64_CTRL_PERF_EN is set.
module tb_rv64_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  ir_opcode = 7'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, ir_write, dmem_req, dmem_we;
  logic [1:0]  alu_op;
  logic        alu_src_a, alu_src_b, reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal_insn;
  logic [2:0]  state_o;
`ifdef RV64_CTRL_PERF_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  int testsRun = 0;
  int failCount = 0;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_OPIMM = 7'b0010011,
                         OP_OP = 7'b0110011, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111,
                         OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_BAD = 7'b1111111;

  always #5 clk = ~clk;

  rv64_multicycle_ctrl #(.RESET_RUN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir_opcode(ir_opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .illegal_insn(illegal_insn),
    .state_o(state_o)
`ifdef RV64_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  wire [14:0] obsCtl = {imem_req, ir_write, dmem_req, dmem_we, alu_op, alu_src_a, alu_src_b,
                        reg_write, wb_sel, pc_write, pc_src, illegal_insn};

  // Expected control vector assembled from named fields, same packing as obsCtl.
  function automatic logic [14:0] ctl(input logic ireq, input logic irw, input logic dreq,
                                      input logic dwe, input logic [1:0] aop, input logic asa,
                                      input logic asb, input logic rw, input logic [1:0] wbs,
                                      input logic pw, input logic [1:0] psrc, input logic ill);
    return {ireq, irw, dreq, dwe, aop, asa, asb, rw, wbs, pw, psrc, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [2:0] expState, input logic [14:0] expCtl);
    checkOutput({tag, ".state"}, 64'(state_o), 64'(expState));
    checkOutput({tag, ".ctl"}, 64'(obsCtl), 64'(expCtl));
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic ir,
                               input logic dr, input logic bt);
    run = r; ir_opcode = op; imem_ready = ir; dmem_ready = dr; branch_taken = bt;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One non-memory instruction from IDLE back to IDLE with zero-wait memories.
  task automatic runSimple(input string tag, input logic [6:0] op, input logic bt,
                           input logic [14:0] expExec, input logic hasWb, input logic [14:0] expWb);
    logic [14:0] fetchCtl;
    fetchCtl = ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    checkCycle({tag, ".idle0"}, 3'd0, 15'd0);
    applyStimulus(1'b1, op, 1'b1, 1'b1, bt);
    tick(); checkCycle({tag, ".fetch"}, 3'd1, fetchCtl);
    run = 1'b0;
    tick(); checkCycle({tag, ".decode"}, 3'd2, 15'd0);
    tick(); checkCycle({tag, ".exec"}, 3'd3, expExec);
    if (hasWb) begin
      tick(); checkCycle({tag, ".wb"}, 3'd5, expWb);
    end
    tick(); checkCycle({tag, ".park"}, 3'd0, 15'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [14:0] fetchCtl, opExec, opWb;
    fetchCtl = ctl(1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    opExec   = ctl(0, 0, 0, 0, 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 0);
    opWb     = ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 2'b00, 0);

    // Reset state, then back-to-back OP at zero wait; run drops mid second instruction.
    applyStimulus(1'b1, OP_OP, 1'b1, 1'b1, 1'b0);
    tick();
    checkCycle("reset", 3'd0, 15'd0);
    rst_n = 1'b1;
    checkCycle("op.idle", 3'd0, 15'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); checkCycle("op.fetch", 3'd1, fetchCtl);
      tick(); checkCycle("op.decode", 3'd2, 15'd0);
      if (i == 1) run = 1'b0;
      tick(); checkCycle("op.exec", 3'd3, opExec);
      tick(); checkCycle("op.wb", 3'd5, opWb);
    end
    tick(); checkCycle("op.park", 3'd0, 15'd0);

    // LOAD with dmem_ready arriving on the fourth MEM cycle.
    applyStimulus(1'b1, OP_LOAD, 1'b1, 1'b0, 1'b0);
    tick(); checkCycle("ld.fetch", 3'd1, fetchCtl);
    run = 1'b0;
    tick(); checkCycle("ld.decode", 3'd2, 15'd0);
    tick(); checkCycle("ld.exec", 3'd3, ctl(0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dmem_ready = 1'b1;
      checkCycle("ld.mem", 3'd4, ctl(0, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    end
    tick(); checkCycle("ld.wb", 3'd5, ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b01, 1, 2'b00, 0));
    tick(); checkCycle("ld.park", 3'd0, 15'd0);

    // STORE at zero wait: pc_write comes from MEM, no WB.
    applyStimulus(1'b1, OP_STORE, 1'b1, 1'b1, 1'b0);
    tick(); checkCycle("st.fetch", 3'd1, fetchCtl);
    run = 1'b0;
    tick(); checkCycle("st.decode", 3'd2, 15'd0);
    tick(); checkCycle("st.exec", 3'd3, ctl(0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0));
    tick(); checkCycle("st.mem", 3'd4, ctl(0, 0, 1, 1, 2'b00, 0, 0, 0, 2'b00, 1, 2'b00, 0));
    tick(); checkCycle("st.park", 3'd0, 15'd0);

    runSimple("br.taken", OP_BRANCH, 1'b1,
              ctl(0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 1, 2'b01, 0), 1'b0, 15'd0);
    runSimple("br.nottaken", OP_BRANCH, 1'b0,
              ctl(0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 1, 2'b00, 0), 1'b0, 15'd0);
    runSimple("opimm", OP_OPIMM, 1'b0,
              ctl(0, 0, 0, 0, 2'b11, 0, 1, 0, 2'b00, 0, 2'b00, 0), 1'b1,
              ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 2'b00, 0));
    runSimple("lui", OP_LUI, 1'b0,
              ctl(0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0), 1'b1,
              ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 1, 2'b00, 0));
    runSimple("auipc", OP_AUIPC, 1'b0,
              ctl(0, 0, 0, 0, 2'b00, 1, 1, 0, 2'b00, 0, 2'b00, 0), 1'b1,
              ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 1, 2'b00, 0));
    runSimple("jal", OP_JAL, 1'b0,
              ctl(0, 0, 0, 0, 2'b00, 1, 1, 0, 2'b00, 0, 2'b00, 0), 1'b1,
              ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 1, 2'b01, 0));
    runSimple("jalr", OP_JALR, 1'b0,
              ctl(0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 2'b00, 0), 1'b1,
              ctl(0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b10, 1, 2'b10, 0));

    // Held fetch, then async reset mid-cycle must drop the request at once.
    applyStimulus(1'b1, OP_OP, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); checkCycle("fwait", 3'd1, ctl(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 0));
    end
    #2 rst_n = 1'b0;
    #1 checkCycle("fetch.rst", 3'd0, 15'd0);
    tick();
    rst_n = 1'b1;

`ifdef RV64_CTRL_PERF_EN
    // Ten OP instructions at zero wait: 40 active cycles, 10 retired.
    applyStimulus(1'b1, OP_OP, 1'b1, 1'b1, 1'b0);
    doReset();
    checkOutput("perf.cyc0", cycle_cnt, 64'd0);
    checkOutput("perf.ret0", instret_cnt, 64'd0);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 38) run = 1'b0;
    end
    checkCycle("perf.park", 3'd0, 15'd0);
    checkOutput("perf.cycle_cnt", cycle_cnt, 64'd40);
    checkOutput("perf.instret_cnt", instret_cnt, 64'd10);
`endif

    // Illegal opcode traps; run is ignored until rst_n pulses.
    applyStimulus(1'b0, OP_BAD, 1'b1, 1'b1, 1'b0);
    doReset();
    run = 1'b1;
    tick(); checkCycle("trap.fetch", 3'd1, fetchCtl);
    tick(); checkCycle("trap.decode", 3'd2, 15'd0);
    for (int i = 0; i < 20; i++) begin
      tick(); checkCycle("trap.hold", 3'd6, ctl(0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 1));
    end
    rst_n = 1'b0;
    #1 checkCycle("trap.rst", 3'd0, 15'd0);
    tick();
    run = 1'b0;
    rst_n = 1'b1;
    tick(); checkCycle("trap.after", 3'd0, 15'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
